data_bus_fabric: RTL
====================

# data_bus_fabric

Parametrised, registered successor to the CPU data-bus decoder. It sits between the core's load/store port and NSLAVES memory-mapped peripherals (RAM, program memory, screen, flash, UART, USB, counters). It decodes by base/mask, holds one outstanding transaction with a ready handshake so slaves can insert wait states, and terminates hung or unmapped accesses with a bus error instead of silently returning 0.

## Interface
Parameters:
- NSLAVES, 8, number of slave ports
- AW, 32, address width
- DW, 32, data width
- SLV_BASE, 0, packed NSLAVES*AW base addresses; slave i occupies bits [i*AW +: AW]
- SLV_MASK, 0, packed NSLAVES*AW masks; slave i hits when (addr & mask_i) == base_i
- DEFAULT_SLV, 0, index used for unmapped addresses when DEFAULT_EN=1
- DEFAULT_EN, 1, 1: unmapped goes to DEFAULT_SLV; 0: unmapped returns error
- TIMEOUT, 255, maximum ACCESS cycles before error; 0 disables the timeout

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- m_addr  in  AW  master address, held stable until m_ready
- m_wdata  in  DW  write data
- m_wstrb  in  DW/8  byte enables
- m_ren  in  1  read request, held until m_ready
- m_wen  in  1  write request, held until m_ready
- m_ready  out  1  one-cycle completion pulse
- m_rdata  out  DW  read data, valid while m_ready=1, otherwise 0
- m_err  out  1  error flag, valid while m_ready=1
- s_addr  out  AW  latched address, broadcast to all slaves
- s_wdata  out  DW  latched write data, broadcast
- s_wstrb  out  DW/8  latched strobes, broadcast
- s_ren  out  NSLAVES  one-hot read strobe
- s_wen  out  NSLAVES  one-hot write strobe
- s_rdata  in  NSLAVES*DW  packed slave read data
- s_ready  in  NSLAVES  per-slave completion

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: when m_ren|m_wen is high, latch addr, wdata, wstrb and the decoded index.
  - Decode is priority: the lowest matching index wins.
  - No match: with DEFAULT_EN=1, use DEFAULT_SLV; with DEFAULT_EN=0, set err_q=1 and go to RESP with no slave access.
  - m_ren&m_wen both high is a protocol error: set err_q=1, go to RESP, no slave access.
  - Otherwise go to ACCESS.
- ACCESS: drive s_ren[idx]/s_wen[idx] every cycle, gated combinationally by the registered state, and increment the cycle counter.
  - s_ready[idx]=1: capture s_rdata[idx] (reads only; writes capture 0), set err_q=0, go to RESP.
  - Counter == TIMEOUT-1 with no ready (TIMEOUT>0): rdata_q=0, err_q=1, go to RESP. Strobes drop on entering RESP.
  - s_ready from non-selected slaves is ignored.
- RESP: m_ready=1 for exactly one cycle with m_rdata=rdata_q and m_err=err_q, then go to IDLE. The master must drop or change its request in the cycle after m_ready.
- Counter width is $clog2(TIMEOUT+1), minimum 1. It clears on IDLE→ACCESS and does not wrap.

## Timing
- Reset, asynchronous: state=IDLE, counter=0, rdata_q=0, err_q=0, idx=0, latched addr/wdata/wstrb=0. All outputs read 0 during reset, including s_* strobes, immediately without waiting for a clock edge. Reset asserted mid-ACCESS aborts the access and no m_ready is issued.
- Latency, request seen in cycle 0:
  - Strobes assert in cycle 1.
  - A zero-wait-state slave (s_ready=1 in cycle 1) gives m_ready in cycle 2.
  - Each wait cycle adds 1.
  - Unmapped or protocol error: m_ready in cycle 1.
  - Timeout: m_ready in cycle TIMEOUT+1.
- Throughput: one transaction per 3 cycles at best. IDLE accepts a new request in the cycle after RESP.
- Address or data changes during ACCESS have no effect because everything is latched.

## Structure
- Shared package bus_pkg holds:
  - the FSM state typedef;
  - named slave indices (SLV_RAM, SLV_PROG, SLV_SCREEN, SLV_FLASH, SLV_UART, SLV_USB, SLV_CNT);
  - base/mask constants derived from config.vh, so top-level instantiation builds SLV_BASE/SLV_MASK from the package.
- One combinational sub-module, bus_addr_decode. It takes addr, SLV_BASE, SLV_MASK and outputs hit and index. It is reusable for the instruction-fetch path.

## Test plan
- Read slave 2 (base 0x2000_0000, mask 0xF000_0000), s_ready tied 1, s_rdata[2]=0xDEAD_BEEF → s_ren=0b100 in cycle 1 only; m_ready in cycle 2 with m_rdata=0xDEADBEEF, m_err=0.
- Write 0x1234_5678 with wstrb=0b0011 to slave 1, s_ready delayed 4 cycles → s_wen[1] high exactly 5 cycles with s_wdata/s_wstrb stable; m_ready in cycle 6, m_err=0.
- Overlapping maps where slaves 0 and 3 both match 0x0000_0100 → slave 0 selected; s_ren[3] never asserts.
- DEFAULT_EN=0, read unmapped 0xFFFF_0000 → no s_* strobe; m_ready in cycle 1 with m_err=1, m_rdata=0. DEFAULT_EN=1, same address → DEFAULT_SLV strobed.
- TIMEOUT=8, slave never ready → strobe high for 8 cycles; m_ready in cycle 9 with m_err=1, m_rdata=0. Next request proceeds normally.
- resetn pulled low in the 3rd ACCESS cycle → strobes drop asynchronously with no m_ready; after release, state is IDLE and a read completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the data-bus fabric: FSM state type, named slave
// slots and the system address map (base/mask per slot) used to build the
// SLV_BASE / SLV_MASK parameters at instantiation.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_t;

    localparam int unsigned BUS_NSLAVES = 8;
    localparam int unsigned BUS_AW      = 32;

    // Named slave slots; slot 7 is spare.
    localparam int unsigned SLV_RAM    = 0;
    localparam int unsigned SLV_PROG   = 1;
    localparam int unsigned SLV_SCREEN = 2;
    localparam int unsigned SLV_FLASH  = 3;
    localparam int unsigned SLV_UART   = 4;
    localparam int unsigned SLV_USB    = 5;
    localparam int unsigned SLV_CNT    = 6;

    // System address map, mirrored from the board configuration.
    localparam logic [BUS_AW-1:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [BUS_AW-1:0] RAM_MASK    = 32'hF000_0000;
    localparam logic [BUS_AW-1:0] PROG_BASE   = 32'h1000_0000;
    localparam logic [BUS_AW-1:0] PROG_MASK   = 32'hF000_0000;
    localparam logic [BUS_AW-1:0] SCREEN_BASE = 32'h2000_0000;
    localparam logic [BUS_AW-1:0] SCREEN_MASK = 32'hF000_0000;
    localparam logic [BUS_AW-1:0] FLASH_BASE  = 32'h3000_0000;
    localparam logic [BUS_AW-1:0] FLASH_MASK  = 32'hF000_0000;
    localparam logic [BUS_AW-1:0] UART_BASE   = 32'h4000_0000;
    localparam logic [BUS_AW-1:0] UART_MASK   = 32'hFFFF_F000;
    localparam logic [BUS_AW-1:0] USB_BASE    = 32'h4000_1000;
    localparam logic [BUS_AW-1:0] USB_MASK    = 32'hFFFF_F000;
    localparam logic [BUS_AW-1:0] CNT_BASE    = 32'h4000_2000;
    localparam logic [BUS_AW-1:0] CNT_MASK    = 32'hFFFF_F000;
    // Spare slot can never match: (addr & 0) is never all ones.
    localparam logic [BUS_AW-1:0] SPARE_BASE  = 32'hFFFF_FFFF;
    localparam logic [BUS_AW-1:0] SPARE_MASK  = 32'h0000_0000;

    localparam logic [BUS_NSLAVES*BUS_AW-1:0] BUS_SLV_BASE = {
        SPARE_BASE, CNT_BASE, USB_BASE, UART_BASE,
        FLASH_BASE, SCREEN_BASE, PROG_BASE, RAM_BASE
    };
    localparam logic [BUS_NSLAVES*BUS_AW-1:0] BUS_SLV_MASK = {
        SPARE_MASK, CNT_MASK, USB_MASK, UART_MASK,
        FLASH_MASK, SCREEN_MASK, PROG_MASK, RAM_MASK
    };

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_bus_fabric_if.sv
// Data-bus signal bundle: master (core load/store) side m_*, broadcast slave
// side s_*. Modports: master = core view, slave = peripheral view,
// fabric = the decoder/fabric itself.
interface data_bus_fabric_if #(
    parameter int unsigned NSLAVES = 8,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
);
    logic [AW-1:0]         m_addr;
    logic [DW-1:0]         m_wdata;
    logic [DW/8-1:0]       m_wstrb;
    logic                  m_ren;
    logic                  m_wen;
    logic                  m_ready;
    logic [DW-1:0]         m_rdata;
    logic                  m_err;

    logic [AW-1:0]         s_addr;
    logic [DW-1:0]         s_wdata;
    logic [DW/8-1:0]       s_wstrb;
    logic [NSLAVES-1:0]    s_ren;
    logic [NSLAVES-1:0]    s_wen;
    logic [NSLAVES*DW-1:0] s_rdata;
    logic [NSLAVES-1:0]    s_ready;

    modport master (
        output m_addr, m_wdata, m_wstrb, m_ren, m_wen,
        input  m_ready, m_rdata, m_err
    );

    modport slave (
        input  s_addr, s_wdata, s_wstrb, s_ren, s_wen,
        output s_rdata, s_ready
    );

    modport fabric (
        input  m_addr, m_wdata, m_wstrb, m_ren, m_wen, s_rdata, s_ready,
        output m_ready, m_rdata, m_err, s_addr, s_wdata, s_wstrb, s_ren, s_wen
    );

endinterface

// File: rtl/bus_addr_decode.sv
// Combinational base/mask address decoder; lowest matching slot wins.
// Ports: addr in, base/mask packed per-slot maps in, hit/idx out.
// Shared with the instruction-fetch path.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int unsigned NSLAVES = 8,
    parameter int unsigned AW      = 32,
    localparam int unsigned IW     = min1_clog2(NSLAVES)
) (
    input  logic [AW-1:0]         addr,
    input  logic [NSLAVES*AW-1:0] base,
    input  logic [NSLAVES*AW-1:0] mask,
    output logic                  hit,
    output logic [IW-1:0]         idx
);

    // Once a slot hits, later (higher) slots are ignored.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (!hit && ((addr & mask[i*AW +: AW]) == base[i*AW +: AW])) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/data_bus_fabric.sv
// Registered data-bus fabric between the core load/store port and NSLAVES
// memory-mapped peripherals. Holds one outstanding transaction, lets slaves
// insert wait states via s_ready, and ends unmapped, malformed or hung
// accesses with a bus error.
// Ports: clk, resetn (async, active-low), bus (fabric modport: m_* from the
// core, s_* broadcast to slaves with one-hot s_ren/s_wen).
module data_bus_fabric
    import bus_pkg::*;
#(
    parameter int unsigned            NSLAVES     = 8,
    parameter int unsigned            AW          = 32,
    parameter int unsigned            DW          = 32,
    parameter logic [NSLAVES*AW-1:0]  SLV_BASE    = '0,
    parameter logic [NSLAVES*AW-1:0]  SLV_MASK    = '0,
    parameter int unsigned            DEFAULT_SLV = 0,
    parameter bit                     DEFAULT_EN  = 1'b1,
    parameter int unsigned            TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  resetn,
    data_bus_fabric_if.fabric     bus
);

    localparam int unsigned IW = min1_clog2(NSLAVES);
    localparam int unsigned CW = min1_clog2(TIMEOUT + 1);
    localparam int unsigned SW = DW / 8;

    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [IW-1:0] DEF_IDX  = IW'(DEFAULT_SLV);

    bus_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           err_q, err_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]  wstrb_q, wstrb_d;
    logic           wr_q, wr_d;

    logic           dec_hit;
    logic [IW-1:0]  dec_idx;
    logic [DW-1:0]  sel_rdata_c;
    logic           sel_ready_c;
    logic [NSLAVES-1:0] ren_c;
    logic [NSLAVES-1:0] wen_c;

    bus_addr_decode #(
        .NSLAVES (NSLAVES),
        .AW      (AW)
    ) u_decode (
        .addr (bus.m_addr),
        .base (SLV_BASE),
        .mask (SLV_MASK),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Response mux from the latched slave index; other slaves are ignored.
    always_comb begin
        sel_rdata_c = '0;
        sel_ready_c = 1'b0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (idx_q == IW'(i)) begin
                sel_rdata_c = bus.s_rdata[i*DW +: DW];
                sel_ready_c = bus.s_ready[i];
            end
        end
    end

    // Next-state and datapath-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        wr_d    = wr_q;

        case (state_q)
            IDLE: begin
                if (bus.m_ren || bus.m_wen) begin
                    addr_d  = bus.m_addr;
                    wdata_d = bus.m_wdata;
                    wstrb_d = bus.m_wstrb;
                    wr_d    = bus.m_wen;
                    idx_d   = dec_hit ? dec_idx : DEF_IDX;
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (bus.m_ren && bus.m_wen) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (!dec_hit && !DEFAULT_EN) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end

            ACCESS: begin
                // Ready wins over a timeout landing in the same cycle.
                if (sel_ready_c) begin
                    rdata_d = wr_q ? '0 : sel_rdata_c;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched transaction registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            wr_q    <= wr_d;
        end
    end

    // One-hot strobes decoded from registered state only, so reset clears them at once.
    always_comb begin
        ren_c = '0;
        wen_c = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if ((state_q == ACCESS) && (idx_q == IW'(i))) begin
                ren_c[i] = !wr_q;
                wen_c[i] = wr_q;
            end
        end
    end

    assign bus.s_ren   = ren_c;
    assign bus.s_wen   = wen_c;
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;
    assign bus.s_wstrb = wstrb_q;

    assign bus.m_ready = (state_q == RESP);
    assign bus.m_rdata = (state_q == RESP) ? rdata_q : '0;
    assign bus.m_err   = (state_q == RESP) && err_q;

endmodule
